serial_subtractor: RTL and testbench

//   Bit-serial WIDTH-bit subtractor: computes DIFF = A - B - B_in, LSB first, one bit per clock.

---
 rtl/serial_subtractor_pkg.sv | 21 ++
 rtl/full_subtractor.sv | 22 ++
 rtl/serial_subtractor.sv | 139 +++++++++++++
 tb/tb_serial_subtractor.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor:
//     - FSM state encodings (legacy-compatible 2-bit localparams)
//     - helper to size the bit counter for a given operand width
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

  // FSM state encodings. 2'd3 is unused and recovers to IDLE.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Width of the bit counter. One extra bit over $clog2 keeps the counter
  // able to represent WIDTH-1 for every legal WIDTH, including WIDTH=1
  // where $clog2 returns 0.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage : serial_subtractor_pkg

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
//   Purely combinational 1-bit full subtractor: computes x - y - bin.
//   Ports:
//     x    in   1  minuend bit
//     y    in   1  subtrahend bit
//     bin  in   1  borrow in
//     d    out  1  difference bit
//     bout out  1  borrow out (1 when x < y + bin)
// -----------------------------------------------------------------------------
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor computing DIFF = A - B - B_in, LSB first,
//   one bit per clock, using a single full_subtractor and a registered borrow.
//   Operands are captured on an accepted start; the result is held in DONE
//   until the next accepted start.
//   Parameters:
//     WIDTH  operand/result width, 1..32
//   Ports:
//     clk    in   1      clock, rising edge
//     rst_n  in   1      asynchronous active-low reset
//     start  in   1      request, honoured only in IDLE or DONE
//     A      in   WIDTH  minuend, captured on the accepting edge
//     B      in   WIDTH  subtrahend, captured on the accepting edge
//     B_in   in   1      borrow-in, captured on the accepting edge
//     busy   out  1      high while computing (RUN)
//     done   out  1      high while the result is held (DONE)
//     DIFF   out  WIDTH  difference, valid while done=1
//     B_out  out  1      final borrow, valid while done=1
//   All outputs come straight from registers.
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] DIFF,
  output logic             B_out
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // State and datapath registers
  logic [1:0]       r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_borrow;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;

  // Combinational helpers
  logic [1:0]       w_state_next;
  logic             w_accept;
  logic             w_running;
  logic             w_last;
  logic             w_d;
  logic             w_bo;
  logic [WIDTH:0]   w_diff_cat;

  // A request is honoured only when no operation is in flight.
  assign w_accept  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_running = (r_state == ST_RUN);
  assign w_last    = (r_count == LAST);

  full_subtractor u_fs (
    .x    (r_a_sh[0]),
    .y    (r_b_sh[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bo)
  );

  // New difference bit enters at the MSB; after WIDTH shifts the first bit
  // computed (the LSB) has reached bit 0. Building the concatenation first
  // keeps the slice legal for WIDTH=1.
  assign w_diff_cat = {w_d, r_diff};

  // Next-state logic
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: if (start)  w_state_next = ST_RUN;
      default:             w_state_next = ST_IDLE;
    endcase
  end

  // Sequential state and datapath
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand/result registers are small flops, not a memory, so
      // they are all reset; a reset mid-operation discards the partial result.
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_borrow <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == ST_RUN);
      r_done  <= (w_state_next == ST_DONE);

      if (w_accept) begin
        r_a_sh   <= A;
        r_b_sh   <= B;
        r_borrow <= B_in;
        r_count  <= '0;
        r_diff   <= '0;
        r_bout   <= 1'b0;
      end else if (w_running) begin
        r_diff   <= w_diff_cat[WIDTH:1];
        r_a_sh   <= r_a_sh >> 1;
        r_b_sh   <= r_b_sh >> 1;
        r_borrow <= w_bo;
        r_count  <= r_count + CW'(1);
        if (w_last) begin
          r_bout <= w_bo;
        end
      end
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign DIFF  = r_diff;
  assign B_out = r_bout;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Scoreboard bench for serial_subtractor. A WIDTH=8 instance is driven by
//   directed and random operations; each accepted operation pushes its
//   expected result and completion cycle, and an independent monitor pops and
//   compares on every rising edge of done. A WIDTH=1 instance is checked
//   exhaustively with direct comparisons.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    int unsigned  cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;

  // WIDTH=8 instance
  logic         start;
  logic [W-1:0] a, b;
  logic         b_in;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         b_out;

  // WIDTH=1 instance
  logic         start1;
  logic [0:0]   a1, b1;
  logic         b_in1;
  logic         busy1, done1;
  logic [0:0]   diff1;
  logic         b_out1;

  int unsigned  cyc;
  int           n_checks;
  int           n_fail;
  exp_t         sb[$];

  serial_subtractor #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a),
    .B     (b),
    .B_in  (b_in),
    .busy  (busy),
    .done  (done),
    .DIFF  (diff),
    .B_out (b_out)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .A     (a1),
    .B     (b1),
    .B_in  (b_in1),
    .busy  (busy1),
    .done  (done1),
    .DIFF  (diff1),
    .B_out (b_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  // Reference: plain integer subtraction, result modulo 2^W, borrow when
  // the true difference is negative.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic bi);
    exp_t e;
    int   r;
    r      = int'(x) - int'(y) - int'(bi);
    e.diff = r[W-1:0];
    e.bout = (r < 0);
    e.cyc  = 0;
    return e;
  endfunction

  // Wait (at negedges) until no operation is in flight, bounded.
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Issue one operation. Called and returns at a negedge. With hold=1 start
  // is left high so the next operation is accepted on the first DONE cycle.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic bi, input bit hold, input bit push,
                       output int unsigned acc_cyc);
    exp_t e;
    wait_idle();
    a     = x;
    b     = y;
    b_in  = bi;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    if (!hold) start = 1'b0;
    if (push) begin
      e     = model(x, y, bi);
      e.cyc = acc_cyc + W;
      sb.push_back(e);
    end
  endtask

  // Monitor: compare on each rising edge of done.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !prev_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("diff",    32'(diff),  32'(e.diff));
          check("b_out",   32'(b_out), 32'(e.bout));
          check("latency", cyc,        e.cyc);
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end
      prev_done = done;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc, prev_acc;
    exp_t        e;
    bit          hold, prev_hold;

    n_checks = 0;
    n_fail   = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    b_in   = 1'b0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    b_in1  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_diff",  32'(diff),  32'd0);
    check("rst_b_out", 32'(b_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    // 200 - 55 = 145, then the result is held while start stays low
    do_op(8'd200, 8'd55, 1'b0, 1'b0, 1'b1, acc);
    wait_idle();
    repeat (3) @(negedge clk);
    check("hold_done", 32'(done), 32'd1);
    check("hold_diff", 32'(diff), 32'd145);
    check("hold_busy", 32'(busy), 32'd0);

    // Wrap-around and borrow-in cases
    do_op(8'd5,   8'd9,   1'b0, 1'b0, 1'b1, acc);
    do_op(8'd0,   8'd0,   1'b1, 1'b0, 1'b1, acc);
    do_op(8'd0,   8'd1,   1'b0, 1'b0, 1'b1, acc);
    do_op(8'd255, 8'd255, 1'b1, 1'b0, 1'b1, acc);
    do_op(8'd255, 8'd0,   1'b0, 1'b0, 1'b1, acc);
    do_op(8'd128, 8'd127, 1'b1, 1'b0, 1'b1, acc);

    // start pulse in the middle of RUN is ignored
    do_op(8'd77, 8'd30, 1'b0, 1'b0, 1'b1, acc);
    repeat (2) @(negedge clk);
    a     = 8'd1;
    b     = 8'd1;
    b_in  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ignored_start_busy", 32'(busy), 32'd1);
    wait_idle();

    // Reset mid-RUN discards the operation
    do_op(8'd99, 8'd11, 1'b0, 1'b0, 1'b0, acc);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",  32'(busy),  32'd0);
    check("midrst_done",  32'(done),  32'd0);
    check("midrst_diff",  32'(diff),  32'd0);
    check("midrst_b_out", 32'(b_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_done", 32'(done), 32'd0);
    do_op(8'd99, 8'd11, 1'b0, 1'b0, 1'b1, acc);

    // Back-to-back with start held high: accepts every W+1 cycles
    do_op(8'd10, 8'd3, 1'b0, 1'b1, 1'b1, prev_acc);
    for (int i = 0; i < 4; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), (i != 3), 1'b1, acc);
      check("b2b_interval", acc - prev_acc, 32'(W + 1));
      check("b2b_done_drop", 32'(done), 32'd0);
      prev_acc = acc;
    end

    // Random sweep, mixing idle gaps and held-start back-to-back runs
    prev_hold = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!prev_hold) repeat ($urandom_range(0, 2)) @(negedge clk);
      hold = (i != 999) && ($urandom_range(0, 3) == 0);
      do_op(8'($urandom), 8'($urandom), 1'($urandom), hold, 1'b1, acc);
      // Inputs changing during RUN must have no effect
      a    = 8'($urandom);
      b    = 8'($urandom);
      b_in = 1'($urandom);
      prev_hold = hold;
    end
    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    // WIDTH=1 instance: all input combinations, done one edge after accept
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      int         r;
      v      = 3'(i);
      a1     = v[0];
      b1     = v[1];
      b_in1  = v[2];
      start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      check("w1_busy", 32'(busy1), 32'd1);
      check("w1_done_low", 32'(done1), 32'd0);
      @(negedge clk);
      r = int'(v[0]) - int'(v[1]) - int'(v[2]);
      check("w1_done",  32'(done1),  32'd1);
      check("w1_diff",  32'(diff1),  32'(r[0]));
      check("w1_b_out", 32'(b_out1), 32'(r < 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_subtractor
